// File: rtl/isa_target_pkg.sv
// -----------------------------------------------------------------------------
// isa_target_pkg
// Shared definitions for the ISA I/O responder:
//   - state_t       : responder state machine encoding
//   - WINDOW_SIZE   : number of byte registers in the decoded I/O window
//   - DEFAULT_BASE  : default window base (only bits [9:4] are decoded)
//   - reg_offset_t  : symbolic names for well-known register offsets
//   - window_hit()  : address/aen decode for the 16-byte window
// -----------------------------------------------------------------------------
package isa_target_pkg;

  localparam int         WINDOW_SIZE  = 16;
  localparam logic [9:0] DEFAULT_BASE = 10'h220;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DRIVE,
    ST_WR_HOLD,
    ST_WR_COMMIT,
    ST_RELEASE
  } state_t;

  // Offsets used by the emulated sound-card style peripherals on the riser.
  typedef enum logic [3:0] {
    REG_DSP_RESET  = 4'h6,
    REG_DSP_DATA   = 4'hA,
    REG_DSP_WRITE  = 4'hC,
    REG_DSP_STATUS = 4'hE
  } reg_offset_t;

  // A cycle belongs to us when it is not a DMA cycle and the upper six
  // address bits match the window base.
  function automatic logic window_hit(input logic [5:0] addr_hi,
                                      input logic       aen,
                                      input logic [5:0] base_hi);
    return !aen && (addr_hi == base_hi);
  endfunction

endpackage

// File: rtl/isa_strobe_sync.sv
// -----------------------------------------------------------------------------
// isa_strobe_sync
// Two-flop synchronizer for an active-low asynchronous bus strobe, followed
// by an edge detector on the synchronized level.
//   clk      in  : system clock
//   reset    in  : asynchronous, active-high
//   strobe_n in  : raw strobe from the bus pin (active-low)
//   level    out : synchronized strobe level (0 = asserted)
//   fall     out : one-clock pulse, strobe became asserted
//   rise     out : one-clock pulse, strobe became deasserted
// -----------------------------------------------------------------------------
module isa_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Strobes idle high, so reset to the deasserted level to avoid a false
  // edge when reset is released.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= strobe_n;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;
  assign rise  = ~prev & sync;

endmodule

// File: rtl/isa_io_target.sv
// -----------------------------------------------------------------------------
// isa_io_target
// Responder end of the riser's 8-bit ISA I/O protocol. Decodes a 16-byte
// window at BASE_ADDR, captures writes into a 16 x 8 register file (with a
// commit strobe to user logic) and returns register contents on reads.
//
// Parameters:
//   BASE_ADDR   : window base, bits [9:4] compared (default 10'h220)
//   WAIT_CYCLES : iochrdy low time in clocks, 1..15 (wait-state build only)
//
// Build option:
//   ISA_TARGET_IOCHRDY_EN : when defined, iochrdy is pulled low for
//                           WAIT_CYCLES clocks on entry to a read or write;
//                           otherwise iochrdy is tied high.
//
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   addr[9:0], aen        : ISA address and DMA address enable
//   iow, ior              : active-low write/read strobes (asynchronous)
//   data_in[7:0]          : SD as seen from the bus
//   data_out[7:0],data_oe : read data and its output enable
//   iochrdy               : channel ready (low = wait state)
//   wr_strobe, wr_index,
//   wr_data               : one-clock commit notification to user logic
//   user_index, user_data : combinational user-side register read port
//   proto_err             : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module isa_io_target
  import isa_target_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR   = DEFAULT_BASE,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] addr,
  input  logic       aen,
  input  logic       iow,
  input  logic       ior,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       iochrdy,
  output logic       wr_strobe,
  output logic [3:0] wr_index,
  output logic [7:0] wr_data,
  input  logic [3:0] user_index,
  output logic [7:0] user_data,
  output logic       proto_err
);

  // ---------------------------------------------------------------------------
  // Strobe synchronization
  // ---------------------------------------------------------------------------
  logic iow_level, iow_fall, iow_rise;
  logic ior_level, ior_fall, ior_rise;

  isa_strobe_sync u_iow_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (iow),
    .level    (iow_level),
    .fall     (iow_fall),
    .rise     (iow_rise)
  );

  isa_strobe_sync u_ior_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (ior),
    .level    (ior_level),
    .fall     (ior_fall),
    .rise     (ior_rise)
  );

  // Data is delayed by the same two stages as the strobe, so the sample
  // taken while the synchronized iow is low is the value that was on the
  // pins while the real strobe was low, not whatever follows its release.
  logic [7:0] data_d1, data_d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_d1 <= '0;
      data_d2 <= '0;
    end else begin
      data_d1 <= data_in;
      data_d2 <= data_d1;
    end
  end

  // ---------------------------------------------------------------------------
  // Responder state machine
  // ---------------------------------------------------------------------------
  state_t state, next_state;

  logic hit;
  logic err_set;
  logic take_index;
  logic take_sample;
  logic commit;

  assign hit = window_hit(addr[9:4], aen, BASE_ADDR[9:4]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    next_state  = state;
    err_set     = 1'b0;
    take_index  = 1'b0;
    take_sample = 1'b0;
    commit      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!iow_level && !ior_level) begin
          err_set    = 1'b1;
          next_state = ST_RELEASE;
        end else if (ior_fall && hit) begin
          take_index = 1'b1;
          next_state = ST_RD_DRIVE;
        end else if (iow_fall && hit) begin
          take_index  = 1'b1;
          take_sample = 1'b1;
          next_state  = ST_WR_HOLD;
        end
      end

      ST_RD_DRIVE: begin
        if (iow_fall) begin
          err_set    = 1'b1;
          next_state = ST_RELEASE;
        end else if (ior_rise) begin
          // The synced level was low since entry, so its rise is the first
          // clock it reads high again.
          next_state = ST_IDLE;
        end
      end

      ST_WR_HOLD: begin
        if (ior_fall) begin
          err_set    = 1'b1;
          next_state = ST_RELEASE;
        end else begin
          take_sample = !iow_level;
          if (iow_rise) next_state = ST_WR_COMMIT;
        end
      end

      ST_WR_COMMIT: begin
        commit     = 1'b1;
        next_state = ST_IDLE;
      end

      ST_RELEASE: begin
        if (iow_level && ior_level) next_state = ST_IDLE;
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: index/sample capture, register file, commit notification
  // ---------------------------------------------------------------------------
  logic [3:0] idx;
  logic [7:0] wr_sample;
  logic [7:0] regs [WINDOW_SIZE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      wr_sample <= '0;
    end else begin
      if (take_index)  idx       <= addr[3:0];
      if (take_sample) wr_sample <= data_d2;
    end
  end

  // NOTE: the register file is reset because the card model must read back
  // all zeros after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WINDOW_SIZE; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[idx] <= wr_sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        wr_index <= idx;
        wr_data  <= wr_sample;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        proto_err <= 1'b0;
    else if (err_set) proto_err <= 1'b1;
  end

  // Decoded straight from the state so a reset drops the bus drive at once.
  assign data_oe   = (state == ST_RD_DRIVE);
  assign data_out  = data_oe ? regs[idx] : '0;
  assign user_data = regs[user_index];

  // ---------------------------------------------------------------------------
  // Wait-state generation
  // ---------------------------------------------------------------------------
`ifdef ISA_TARGET_IOCHRDY_EN
  logic [3:0] wait_cnt;
  logic       entering;
  logic       staying;

  assign entering = (state == ST_IDLE) &&
                    ((next_state == ST_RD_DRIVE) || (next_state == ST_WR_HOLD));
  assign staying  = (next_state == ST_RD_DRIVE) || (next_state == ST_WR_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (entering) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (!staying) begin
      // Never leave the channel stalled once the cycle is over.
      wait_cnt <= '0;
    end else if (wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign iochrdy = (wait_cnt == 4'd0);
`else
  assign iochrdy = 1'b1;
`endif

endmodule

// File: tb/tb_isa_io_target.sv
// -----------------------------------------------------------------------------
// tb_isa_io_target
// Self-checking bench for isa_io_target. Bus cycles are driven at pin level;
// expectations come from a transaction-level model: a 16-entry byte array
// plus the documented pin-to-output latencies.
// -----------------------------------------------------------------------------
module tb_isa_io_target;

  localparam logic [9:0] BASE = 10'h220;
  localparam int         WAIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] addr;
  logic       aen;
  logic       iow;
  logic       ior;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       iochrdy;
  logic       wr_strobe;
  logic [3:0] wr_index;
  logic [7:0] wr_data;
  logic [3:0] user_index;
  logic [7:0] user_data;
  logic       proto_err;

  always #5 clk = ~clk;

  isa_io_target #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .aen        (aen),
    .iow        (iow),
    .ior        (ior),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .iochrdy    (iochrdy),
    .wr_strobe  (wr_strobe),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .user_index (user_index),
    .user_data  (user_data),
    .proto_err  (proto_err)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] model_regs [16];

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are read 2 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic model_hit(input logic [9:0] a, input logic e);
    return !e && (a >= BASE) && (a < BASE + 10'd16);
  endfunction

  task automatic check_user_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      user_index = 4'(i);
      #1;
      check($sformatf("%s user_data[%0d]", tag, i), 32'(user_data), 32'(model_regs[i]));
    end
  endtask

  // One write cycle: iow low for 'low' clocks, data changes after release.
  task automatic bus_write(input string tag, input logic [9:0] a, input logic e,
                           input logic [7:0] d, input int low);
    int         strobes   = 0;
    int         strobe_at = -1;
    int         oe_seen   = 0;
    logic [3:0] got_idx   = '0;
    logic [7:0] got_data  = '0;
    logic       exp_hit   = model_hit(a, e);
    addr    = a;
    aen     = e;
    data_in = d;
    step();
    iow = 1'b0;
    for (int n = 1; n <= low + 8; n++) begin
      step();
      if (wr_strobe) begin
        strobes++;
        strobe_at = n;
        got_idx   = wr_index;
        got_data  = wr_data;
      end
      if (data_oe) oe_seen++;
      if (n == low) begin
        iow     = 1'b1;
        data_in = 8'($urandom);
      end
    end
    check({tag, " strobe count"}, 32'(strobes), exp_hit ? 32'd1 : 32'd0);
    check({tag, " data_oe during write"}, 32'(oe_seen), 32'd0);
    if (exp_hit) begin
      check({tag, " strobe latency"}, 32'(strobe_at), 32'(low + 4));
      check({tag, " wr_index"}, 32'(got_idx), 32'(a - BASE));
      check({tag, " wr_data"}, 32'(got_data), 32'(d));
      model_regs[a - BASE] = d;
    end
    aen = 1'b0;
  endtask

  // One read cycle: ior low for 'low' clocks.
  task automatic bus_read(input string tag, input logic [9:0] a, input logic e,
                          input int low);
    int         oe_first = -1;
    int         oe_last  = -1;
    int         oe_cnt   = 0;
    int         bad_data = 0;
    int         rdy_low  = 0;
    int         rdy_first = -1;
    logic       exp_hit  = model_hit(a, e);
    logic [7:0] exp_data = exp_hit ? model_regs[a - BASE] : 8'h00;
    addr = a;
    aen  = e;
    step();
    ior = 1'b0;
    for (int n = 1; n <= low + 6; n++) begin
      step();
      if (data_oe) begin
        oe_cnt++;
        if (oe_first < 0) oe_first = n;
        oe_last = n;
        if (data_out !== exp_data) bad_data++;
      end
      if (!iochrdy) begin
        rdy_low++;
        if (rdy_first < 0) rdy_first = n;
      end
      if (n == low) ior = 1'b1;
    end
    check({tag, " data_oe clocks"}, 32'(oe_cnt), exp_hit ? 32'(low) : 32'd0);
    if (exp_hit) begin
      check({tag, " data_oe rise"}, 32'(oe_first), 32'd3);
      check({tag, " data_oe fall"}, 32'(oe_last + 1), 32'(low + 3));
      check({tag, " data_out"}, 32'(bad_data), 32'd0);
    end
`ifdef ISA_TARGET_IOCHRDY_EN
    check({tag, " iochrdy low clocks"}, 32'(rdy_low), exp_hit ? 32'(WAIT) : 32'd0);
    if (exp_hit) check({tag, " iochrdy low start"}, 32'(rdy_first), 32'd3);
`else
    check({tag, " iochrdy low clocks"}, 32'(rdy_low), 32'd0);
`endif
    aen = 1'b0;
  endtask

  initial begin
    int         strobes;
    int         oe_seen;
    logic [9:0] a;
    logic       e;

    reset      = 1'b1;
    addr       = '0;
    aen        = 1'b0;
    iow        = 1'b1;
    ior        = 1'b1;
    data_in    = '0;
    user_index = '0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset data_oe", 32'(data_oe), 32'h0);
    check("reset iochrdy", 32'(iochrdy), 32'h1);
    check("reset wr_strobe", 32'(wr_strobe), 32'h0);
    check("reset wr_index", 32'(wr_index), 32'h0);
    check("reset wr_data", 32'(wr_data), 32'h0);
    check("reset proto_err", 32'(proto_err), 32'h0);
    check_user_regs("reset");

    // Directed: write hit, read back, miss, DMA
    bus_write("wr 22C", 10'h22C, 1'b0, 8'hA5, 3);
    user_index = 4'hC;
    #1;
    check("user_data C after write", 32'(user_data), 32'hA5);
    bus_read("rd 22C", 10'h22C, 1'b0, 4);
    bus_write("wr miss 230", 10'h230, 1'b0, 8'h3C, 3);
    bus_write("wr dma 22C", 10'h22C, 1'b1, 8'h5A, 3);
    bus_read("rd miss 21F", 10'h21F, 1'b0, 4);
    bus_read("rd dma 22C", 10'h22C, 1'b1, 4);
    bus_write("wr 220 min width", 10'h220, 1'b0, 8'h81, 2);
    bus_write("wr 22F", 10'h22F, 1'b0, 8'h7E, 5);
    bus_read("rd 22F", 10'h22F, 1'b0, 5);
    check_user_regs("after directed");

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) != 0) ? (BASE + 10'($urandom_range(0, 15)))
                                      : 10'($urandom);
      e = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1)
        bus_write($sformatf("rand%0d wr %0h", t, a), a, e, 8'($urandom),
                  int'($urandom_range(2, 5)));
      else
        bus_read($sformatf("rand%0d rd %0h", t, a), a, e,
                 int'($urandom_range(4, 6)));
    end
    check("proto_err after clean traffic", 32'(proto_err), 32'h0);
    check_user_regs("after random");

    // Collision: both strobes fall in the same clock
    addr    = 10'h22C;
    data_in = 8'hEE;
    step();
    strobes = 0;
    oe_seen = 0;
    iow = 1'b0;
    ior = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (wr_strobe) strobes++;
      if (data_oe) oe_seen++;
      if (n == 3) begin
        iow = 1'b1;
        ior = 1'b1;
      end
    end
    check("collision proto_err", 32'(proto_err), 32'h1);
    check("collision strobes", 32'(strobes), 32'h0);
    check("collision data_oe", 32'(oe_seen), 32'h0);
    check_user_regs("after collision");
    bus_write("post-collision wr 226", 10'h226, 1'b0, 8'h42, 3);
    bus_read("post-collision rd 226", 10'h226, 1'b0, 4);
    check("proto_err sticky", 32'(proto_err), 32'h1);

    // Reset in the middle of a read
    addr = 10'h22C;
    step();
    ior = 1'b0;
    repeat (4) step();
    check("mid-read data_oe before reset", 32'(data_oe), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("reset mid-read data_oe", 32'(data_oe), 32'h0);
    check("reset mid-read iochrdy", 32'(iochrdy), 32'h1);
    check("reset mid-read proto_err", 32'(proto_err), 32'h0);
    check("reset mid-read wr_strobe", 32'(wr_strobe), 32'h0);
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    check_user_regs("reset mid-read");
    ior = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    bus_write("post-reset wr 22A", 10'h22A, 1'b0, 8'hC3, 3);
    bus_read("post-reset rd 22A", 10'h22A, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d failures so far, expected completion", tests_failed);
    $fatal(1);
  end

endmodule
